// File: rtl/led_pattern_gen.sv
// LED pattern generator: chase-up, chase-down, ping-pong and centre-out/in
// patterns, advanced one step every speed+1 beat cycles.
module led_pattern_gen #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic                    beat,
  input  logic                    rst,
  input  logic [3:0]              func,
  input  logic [1:0]              mode,
  input  logic [PW-1:0]           speed,
  input  logic                    pause,
  output logic [N-1:0]            L,
  output logic [$clog2(2*N)-1:0]  pos,
  output logic                    wrap
);

  localparam int PHW = $clog2(2*N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_CENTRE   = 2'd3
  } mode_e;

  logic [PW-1:0]  pc_q, pc_d;
  logic [PHW-1:0] ph_q, ph_d;
  mode_e          mode_q, mode_d;
  logic [N-1:0]   led_q, led_d;
  logic           wrap_q, wrap_d;

  logic           blank;
  logic           modeChange;
  logic           step;
  logic [PHW-1:0] lastPhase;
  logic [PHW-1:0] centreDist;
  logic [N-1:0]   stepPattern;

  assign blank      = (func == 4'b0000) || (func == 4'b0011);
  assign modeChange = (mode_e'(mode) != mode_q);
  assign step       = (pc_q == speed);
  assign lastPhase  = (mode_q == MODE_PINGPONG) ? PHW'(2*N-1) : PHW'(N-1);

  // Pattern that the next step will load, from the registered mode and phase.
  always_comb begin
    stepPattern = '0;
    centreDist  = '0;
    case (mode_q)
      MODE_UP:   stepPattern = ONE << ph_q;
      MODE_DOWN: stepPattern = ONE << (PHW'(N-1) - ph_q);
      MODE_PINGPONG: begin
        if (ph_q < PHW'(N)) begin
          stepPattern = ONE << ph_q;
        end else begin
          stepPattern = ONE << (PHW'(2*N-1) - ph_q);
        end
      end
      MODE_CENTRE: begin
        centreDist  = (ph_q < PHW'(N/2)) ? ph_q : (PHW'(N-1) - ph_q);
        stepPattern = (ONE << (PHW'(N/2-1) - centreDist)) |
                      (ONE << (PHW'(N/2) + centreDist));
      end
      default: stepPattern = '0;
    endcase
  end

  // Priority below reset: blank, then mode change, then pause, then step.
  always_comb begin
    pc_d   = pc_q;
    ph_d   = ph_q;
    mode_d = mode_q;
    led_d  = led_q;
    wrap_d = 1'b0;
    if (blank) begin
      pc_d   = '0;
      ph_d   = '0;
      led_d  = '0;
      mode_d = mode_e'(mode);
    end else if (modeChange) begin
      mode_d = mode_e'(mode);
      pc_d   = '0;
      ph_d   = '0;
    end else if (!pause) begin
      if (step) begin
        led_d  = stepPattern;
        pc_d   = '0;
        wrap_d = (ph_q == lastPhase);
        ph_d   = (ph_q == lastPhase) ? '0 : ph_q + PHW'(1);
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge beat) begin
    if (rst) begin
      pc_q   <= '0;
      ph_q   <= '0;
      mode_q <= MODE_UP;
      led_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ph_q   <= ph_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      wrap_q <= wrap_d;
    end
  end

  assign L    = led_q;
  assign pos  = ph_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed scenarios followed by
// randomized stimulus, all compared against a rule-level reference model.
module tb_led_pattern_gen;

  localparam int N  = 8;
  localparam int PW = 4;

  logic         beat = 1'b0;
  logic         rst;
  logic [3:0]   func;
  logic [1:0]   mode;
  logic [PW-1:0] speed;
  logic         pause;
  logic [N-1:0] L;
  logic [3:0]   pos;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  int       mMode, mPh, mPc;
  logic [N-1:0] mL;
  logic     mWrap;

  logic [7:0] chaseUp [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] centre  [8] = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h81, 8'h42, 8'h24, 8'h18};

  led_pattern_gen #(.N(N), .PW(PW)) dut (
    .beat  (beat),
    .rst   (rst),
    .func  (func),
    .mode  (mode),
    .speed (speed),
    .pause (pause),
    .L     (L),
    .pos   (pos),
    .wrap  (wrap)
  );

  always #5 beat = ~beat;

  // LEDs lit at phase ph, derived from which LED index(es) each mode visits.
  function automatic int patternOf(input int m, input int ph);
    int s;
    case (m)
      0: return 2 ** ph;
      1: return 2 ** (N - 1 - ph);
      2: return (ph < N) ? 2 ** ph : 2 ** (2 * N - 1 - ph);
      default: begin
        s = (ph < N / 2) ? ph : N - 1 - ph;
        return 2 ** (N / 2 - 1 - s) + 2 ** (N / 2 + s);
      end
    endcase
  endfunction

  task automatic modelEdge(input logic r, input logic [3:0] f, input int m,
                           input int s, input logic p);
    int period;
    if (r) begin
      mMode = 0; mPh = 0; mPc = 0; mL = '0; mWrap = 1'b0;
    end else if (f == 4'd0 || f == 4'd3) begin
      mMode = m; mPh = 0; mPc = 0; mL = '0; mWrap = 1'b0;
    end else if (m != mMode) begin
      mMode = m; mPh = 0; mPc = 0; mWrap = 1'b0;
    end else if (p) begin
      mWrap = 1'b0;
    end else if (mPc == s) begin
      period = (mMode == 2) ? 2 * N : N;
      mL     = N'(patternOf(mMode, mPh));
      mWrap  = (mPh == period - 1);
      mPh    = (mPh + 1) % period;
      mPc    = 0;
    end else begin
      mPc   = (mPc + 1) % (2 ** PW);
      mWrap = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (L === mL) else begin
      errors++;
      $error("[TB] FAIL %s L observed=%h expected=%h", tag, L, mL);
    end
    checks++;
    assert (pos === 4'(mPh)) else begin
      errors++;
      $error("[TB] FAIL %s pos observed=%0d expected=%0d", tag, pos, mPh);
    end
    checks++;
    assert (wrap === mWrap) else begin
      errors++;
      $error("[TB] FAIL %s wrap observed=%b expected=%b", tag, wrap, mWrap);
    end
  endtask

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] f, input logic [1:0] m,
                               input logic [PW-1:0] s, input logic p, input string tag);
    rst = r; func = f; mode = m; speed = s; pause = p;
    @(posedge beat);
    modelEdge(r, f, int'(m), int'(s), p);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [1:0]    rMode;
    logic [PW-1:0] rSpeed;
    rst = 1'b1; func = 4'd0; mode = 2'd0; speed = '0; pause = 1'b0;
    mMode = 0; mPh = 0; mPc = 0; mL = '0; mWrap = 1'b0;
    $display("[TB] start");

    applyStimulus(1'b1, 4'd1, 2'd0, 4'd0, 1'b0, "reset");
    applyStimulus(1'b1, 4'd1, 2'd0, 4'd0, 1'b0, "reset");
    checkValue("resetL", L, 8'h00);

    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b0, 4'd1, 2'd0, 4'd0, 1'b0, "chaseUp");
      checkValue("chaseUpL", L, chaseUp[k]);
      checkValue("chaseUpWrap", {7'd0, wrap}, (k == 7) ? 8'd1 : 8'd0);
    end

    applyStimulus(1'b0, 4'd1, 2'd2, 4'd0, 1'b0, "toPingPong");
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b0, 4'd1, 2'd2, 4'd0, 1'b0, "pingPong");
      if (k == 14) checkValue("pingPongPos15", {4'd0, pos}, 8'd15);
      if (k == 15) checkValue("pingPongPos0", {4'd0, pos}, 8'd0);
    end

    applyStimulus(1'b0, 4'd1, 2'd3, 4'd2, 1'b0, "toCentre");
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 4'd1, 2'd3, 4'd2, 1'b0, "centre");
      checkValue("centreL", L, centre[k]);
    end

    applyStimulus(1'b0, 4'd1, 2'd0, 4'd0, 1'b0, "toChase");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'd1, 2'd0, 4'd0, 1'b0, "chaseTo08");
    checkValue("prePauseL", L, 8'h08);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'd1, 2'd0, 4'd0, 1'b1, "pause");
      checkValue("pauseL", L, 8'h08);
      checkValue("pauseWrap", {7'd0, wrap}, 8'd0);
    end
    applyStimulus(1'b0, 4'd1, 2'd0, 4'd0, 1'b0, "release");
    checkValue("releaseL", L, 8'h10);

    applyStimulus(1'b0, 4'd1, 2'd2, 4'd0, 1'b0, "toPingPong2");
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 4'd1, 2'd2, 4'd0, 1'b0, "toPos12");
    checkValue("pos12", {4'd0, pos}, 8'd12);
    applyStimulus(1'b0, 4'd1, 2'd1, 4'd0, 1'b0, "switchDown");
    checkValue("switchPos", {4'd0, pos}, 8'd0);
    applyStimulus(1'b0, 4'd1, 2'd1, 4'd0, 1'b0, "firstDown");
    checkValue("firstDownL", L, 8'h80);

    applyStimulus(1'b0, 4'd1, 2'd1, 4'd0, 1'b0, "down");
    applyStimulus(1'b0, 4'd3, 2'd1, 4'd0, 1'b0, "blank");
    checkValue("blankL", L, 8'h00);
    applyStimulus(1'b0, 4'd1, 2'd1, 4'd1, 1'b0, "unblank");
    applyStimulus(1'b0, 4'd1, 2'd1, 4'd1, 1'b0, "unblankStep");
    checkValue("unblankL", L, 8'h80);
    applyStimulus(1'b1, 4'd1, 2'd2, 4'd1, 1'b0, "rstModeChange");
    checkValue("rstL", L, 8'h00);

    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 4'd1, 2'd0, 4'd9, 1'b0, "slowCount");
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 4'd1, 2'd0, 4'd2, 1'b0, "speedDrop");
    checkValue("speedDropNoStep", L, 8'h00);
    applyStimulus(1'b0, 4'd1, 2'd0, 4'd2, 1'b0, "speedDropStep");
    checkValue("speedDropL", L, 8'h01);

    rMode  = 2'd0;
    rSpeed = 4'd1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) rMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) rSpeed = PW'($urandom_range(0, 5));
      applyStimulus(($urandom_range(0, 99) < 2), 4'($urandom_range(0, 15)), rMode, rSpeed,
                    ($urandom_range(0, 5) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
